// File: rtl/fir_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fir_pkg                                                              |
// | Shared widths, saturation limits and the round/shift/saturate helper |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package fir_pkg;

   localparam int SAMPLE_W = 16;
   localparam int ACC_W    = 32;
   localparam int SAT_MAX  = 32767;
   localparam int SAT_MIN  = -32768;

   localparam logic signed [ACC_W:0] SAT_MAX_X = SAT_MAX;
   localparam logic signed [ACC_W:0] SAT_MIN_X = SAT_MIN;

   typedef struct packed {
      logic                       sat;
      logic signed [SAMPLE_W-1:0] data;
   } sat_result_t;

   // One extra bit of headroom keeps the rounding bias from wrapping.
   function automatic sat_result_t sat_round(input logic signed [ACC_W-1:0] x,
                                             input int                      shift);
      logic signed [ACC_W:0] bias;
      logic signed [ACC_W:0] rnd;
      logic signed [ACC_W:0] shf;
      sat_result_t           res;
      bias = '0;
      if (shift > 0) begin
         bias = {{ACC_W{1'b0}}, 1'b1} <<< (shift - 1);
      end
      rnd = $signed({x[ACC_W-1], x}) + bias;
      shf = rnd >>> shift;
      res.sat  = 1'b0;
      res.data = shf[SAMPLE_W-1:0];
      if (shf > SAT_MAX_X) begin
         res.sat  = 1'b1;
         res.data = SAMPLE_W'(SAT_MAX);
      end else if (shf < SAT_MIN_X) begin
         res.sat  = 1'b1;
         res.data = SAMPLE_W'(SAT_MIN);
      end
      return res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_fifo                                                            |
// | Single-clock FIFO; a push into a full FIFO lands if a pop coincides  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sync_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_rd_en;
   logic             w_wr_en;

   assign full    = (r_count == (AW+1)'(DEPTH));
   assign empty   = (r_count == '0);
   assign level   = r_count;
   assign w_rd_en = pop && !empty;
   assign w_wr_en = push && (!full || w_rd_en);
   assign dout    = empty ? '0 : r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[r_wr_ptr] <= din;
      end
   end

   // Power-of-two depth lets the pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_rd_en) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         if (w_wr_en && !w_rd_en) begin
            r_count <= r_count + (AW+1)'(1);
         end else if (w_rd_en && !w_wr_en) begin
            r_count <= r_count - (AW+1)'(1);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/fir_out_conditioner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fir_out_conditioner                                                  |
// | Round/scale/saturate, decimate and buffer the FIR output stream      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fir_out_conditioner
   import fir_pkg::*;
#(
   parameter int SHIFT = 4,
   parameter int DECIM = 2,
   parameter int DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic signed [ACC_W-1:0]     y_in,
   input  logic                        in_valid,
   output logic signed [SAMPLE_W-1:0]  out_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [$clog2(DEPTH):0]      level,
   output logic                        sat_seen,
   output logic                        overflow
);

   localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;

   sat_result_t          w_rnd;
   logic [PH_W-1:0]      r_phase;
   logic                 r_s1_valid;
   logic [SAMPLE_W-1:0]  r_s1_data;
   logic                 r_sat_seen;
   logic                 r_overflow;
   logic                 w_pop;
   logic                 w_full;
   logic                 w_empty;
   logic                 w_drop;
   logic [SAMPLE_W-1:0]  w_fifo_dout;

   assign w_rnd     = sat_round(y_in, SHIFT);
   assign w_pop     = out_valid && out_ready;
   assign w_drop    = r_s1_valid && w_full && !w_pop;
   assign out_valid = !w_empty;
   assign out_data  = $signed(w_fifo_dout);
   assign sat_seen  = r_sat_seen;
   assign overflow  = r_overflow;

   // r_s1_valid marks a kept sample; discarded samples still update sat_seen.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_phase    <= '0;
         r_s1_valid <= 1'b0;
         r_s1_data  <= '0;
         r_sat_seen <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         r_s1_valid <= in_valid && (r_phase == '0);
         if (in_valid) begin
            r_s1_data <= w_rnd.data;
            if (r_phase == PH_W'(DECIM - 1)) begin
               r_phase <= '0;
            end else begin
               r_phase <= r_phase + PH_W'(1);
            end
            if (w_rnd.sat) begin
               r_sat_seen <= 1'b1;
            end
         end
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   sync_fifo #(
      .WIDTH (SAMPLE_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (r_s1_valid),
      .pop   (w_pop),
      .din   (r_s1_data),
      .dout  (w_fifo_dout),
      .full  (w_full),
      .empty (w_empty),
      .level (level)
   );

endmodule
`default_nettype wire

// File: tb/tb_fir_out_conditioner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fir_out_conditioner                                               |
// | Directed bench: DECIM=1 and DECIM=2 instances side by side           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_fir_out_conditioner;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rst_a, iv_a, rdy_a, ov_a, sat_a, ovf_a;
   logic signed [31:0] y_a;
   logic signed [15:0] od_a;
   logic [2:0]         lvl_a;
   logic               rst_b, iv_b, rdy_b, ov_b, sat_b, ovf_b;
   logic signed [31:0] y_b;
   logic signed [15:0] od_b;
   logic [2:0]         lvl_b;

   fir_out_conditioner #(.SHIFT(4), .DECIM(1), .DEPTH(4)) dut_a (
      .clk(clk), .reset(rst_a), .y_in(y_a), .in_valid(iv_a), .out_data(od_a),
      .out_valid(ov_a), .out_ready(rdy_a), .level(lvl_a), .sat_seen(sat_a),
      .overflow(ovf_a));

   fir_out_conditioner #(.SHIFT(4), .DECIM(2), .DEPTH(4)) dut_b (
      .clk(clk), .reset(rst_b), .y_in(y_b), .in_valid(iv_b), .out_data(od_b),
      .out_valid(ov_b), .out_ready(rdy_b), .level(lvl_b), .sat_seen(sat_b),
      .overflow(ovf_b));

   int checks   = 0;
   int failures = 0;
   int q[$];

   typedef struct {
      logic signed [31:0] y;
      int                 exp;
      int                 exp_sat;
   } vec_t;
   vec_t vecs[13];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic collect_a(input int n);
      for (int i = 0; i < n; i++) begin
         if (ov_a && rdy_a) q.push_back(int'(od_a));
         step();
      end
   endtask

   task automatic collect_b(input int n);
      for (int i = 0; i < n; i++) begin
         if (ov_b && rdy_b) q.push_back(int'(od_b));
         step();
      end
   endtask

   task automatic chk_q(input string name, input int e0, input int e1, input int e2,
                        input int e3, input int e4, input int n);
      int exp[5];
      exp = '{e0, e1, e2, e3, e4};
      chk({name, "_count"}, q.size(), n);
      for (int k = 0; k < n; k++)
         chk($sformatf("%s_%0d", name, k), (k < q.size()) ? q[k] : -99999, exp[k]);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int first_valid;
      vecs[0]  = '{32'sd24,       2,      0};
      vecs[1]  = '{32'sd23,       1,      0};
      vecs[2]  = '{-32'sd24,      -1,     0};
      vecs[3]  = '{-32'sd25,      -2,     0};
      vecs[4]  = '{32'sd8,        1,      0};
      vecs[5]  = '{-32'sd8,       0,      0};
      vecs[6]  = '{-32'sd9,       -1,     0};
      vecs[7]  = '{32'sd524279,   32767,  0};
      vecs[8]  = '{-32'sd524288,  -32768, 0};
      vecs[9]  = '{32'sd524280,   32767,  1};
      vecs[10] = '{32'h7FFFFFFF,  32767,  1};
      vecs[11] = '{32'h80000000,  -32768, 1};
      vecs[12] = '{32'sd24,       2,      1};

      rst_a = 1; iv_a = 0; rdy_a = 1; y_a = 0;
      rst_b = 1; iv_b = 0; rdy_b = 1; y_b = 0;
      step(); step();
      rst_a = 0; rst_b = 0;
      chk("rst_a_valid", int'(ov_a), 0);
      chk("rst_a_data", int'(od_a), 0);
      chk("rst_a_level", int'(lvl_a), 0);
      chk("rst_a_flags", int'({sat_a, ovf_a}), 0);
      chk("rst_b_valid", int'(ov_b), 0);
      chk("rst_b_level", int'(lvl_b), 0);

      // Rounding and saturation table on the DECIM=1 instance
      foreach (vecs[i]) begin
         y_a = vecs[i].y; iv_a = 1;
         step();
         iv_a = 0;
         step();
         chk($sformatf("vec%0d_valid", i), int'(ov_a), 1);
         chk($sformatf("vec%0d_data", i), int'(od_a), vecs[i].exp);
         chk($sformatf("vec%0d_sat", i), int'(sat_a), vecs[i].exp_sat);
         step();
      end
      chk("vec_drained", int'(lvl_a), 0);

      // Decimation, back-to-back input
      q.delete();
      first_valid = -1;
      for (int i = 0; i < 10; i++) begin
         iv_b = (i < 6);
         y_b = 32'(16 * (i + 1));
         if (ov_b && first_valid < 0) begin
            first_valid = i;
            chk("decim_first_data", int'(od_b), 1);
         end
         if (ov_b) q.push_back(int'(od_b));
         step();
      end
      iv_b = 0;
      chk("decim_first_valid_cycle", first_valid, 2);
      chk_q("decim", 1, 3, 5, 0, 0, 3);

      // Decimation with in_valid gaps
      q.delete();
      for (int i = 0; i < 18; i++) begin
         iv_b = ((i % 2) == 0) && (i < 12);
         y_b = 32'(16 * (i / 2 + 1));
         if (ov_b) q.push_back(int'(od_b));
         step();
      end
      iv_b = 0;
      chk_q("decim_gap", 1, 3, 5, 0, 0, 3);
      chk("decim_sat", int'(sat_b), 0);

      // Backpressure and overflow
      rdy_a = 0;
      for (int k = 0; k < 5; k++) begin
         y_a = 32'(16 * (k + 1)); iv_a = 1;
         step();
      end
      iv_a = 0;
      step(); step();
      chk("bp_level", int'(lvl_a), 4);
      chk("bp_overflow", int'(ovf_a), 1);
      chk("bp_head_held", int'(od_a), 1);
      rdy_a = 1;
      q.delete();
      collect_a(8);
      chk_q("bp_drain", 1, 2, 3, 4, 0, 4);
      chk("bp_empty", int'(lvl_a), 0);
      chk("bp_overflow_sticky", int'(ovf_a), 1);

      // Full FIFO with push and pop on the same edge
      rst_a = 1; step(); rst_a = 0;
      chk("fp_rst_overflow", int'(ovf_a), 0);
      rdy_a = 0;
      for (int k = 0; k < 5; k++) begin
         y_a = 32'(16 * (k + 1)); iv_a = 1;
         step();
      end
      iv_a = 0;
      chk("fp_full", int'(lvl_a), 4);
      rdy_a = 1;
      q.delete();
      if (ov_a) q.push_back(int'(od_a));
      step();
      chk("fp_level_same", int'(lvl_a), 4);
      chk("fp_no_overflow", int'(ovf_a), 0);
      collect_a(8);
      chk_q("fp_drain", 1, 2, 3, 4, 5, 5);
      chk("fp_no_overflow_end", int'(ovf_a), 0);

      // Reset mid-stream; the sample presented during reset is ignored
      rdy_b = 0;
      for (int k = 0; k < 5; k++) begin
         y_b = (k == 0) ? 32'h7FFFFFFF : 32'(16 * k); iv_b = 1;
         step();
      end
      iv_b = 0;
      step(); step();
      chk("mr_level", int'(lvl_b), 3);
      chk("mr_sat", int'(sat_b), 1);
      chk("mr_head", int'(od_b), 32767);
      rst_b = 1; y_b = 32'sd16; iv_b = 1;
      step();
      rst_b = 0; iv_b = 0;
      chk("mr_valid", int'(ov_b), 0);
      chk("mr_level0", int'(lvl_b), 0);
      chk("mr_flags", int'({sat_b, ovf_b}), 0);
      chk("mr_data", int'(od_b), 0);
      step();
      chk("mr_no_ghost", int'(ov_b), 0);
      y_b = 32'sd48; iv_b = 1;
      step();
      iv_b = 0;
      step();
      chk("mr_kept_valid", int'(ov_b), 1);
      chk("mr_kept_data", int'(od_b), 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fir_out_conditioner.md
Name: fir_out_conditioner

Overview:
- Sits directly downstream of fir_filter and consumes its 32-bit signed y_out stream.
- Rounds and scales each sample, saturates it to 16-bit signed, and decimates by a fixed factor.
- Buffers kept samples in a small FIFO with a valid/ready handshake toward the consumer (DAC or packetiser).
- Reports saturation and overflow through sticky status flags.

Parameters:
SHIFT, 4, arithmetic right-shift applied after rounding; legal range 0..16
DECIM, 2, decimation factor; legal range 1..16; keep 1 of every DECIM accepted samples
DEPTH, 4, FIFO depth in samples; power of two, 2..64

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
y_in  in  32  signed FIR output sample (connects to fir_filter y_out)
in_valid  in  1  y_in valid this cycle; tie high when the FIR produces every cycle
out_data  out  16  signed conditioned sample at FIFO head
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts out_data when out_valid && out_ready
level  out  $clog2(DEPTH)+1  current FIFO occupancy
sat_seen  out  1  sticky: a kept or discarded sample saturated
overflow  out  1  sticky: a kept sample was dropped because the FIFO was full

Behaviour:
- Reset: one clock cycle with reset=1 sets out_data=0, out_valid=0, level=0, sat_seen=0, overflow=0, decimation counter=0, and stage-1 valid=0.
  - In-flight and buffered samples are discarded.
  - reset has priority over every other event in the same cycle.
- Stage 1 (registered, on an edge with in_valid=1):
  - r = y_in + 2^(SHIFT-1). When SHIFT=0, no addition.
  - Compute in 33 bits so that no wrap occurs.
  - s = r >>> SHIFT (arithmetic).
  - If s > 32767, store 32767. If s < -32768, store -32768. In both cases set sat_seen.
  - Rounding rule: round half toward +infinity.
- Decimation counter:
  - Advances only on in_valid; wraps from DECIM-1 to 0.
  - A sample accepted while the counter is 0 is marked keep.
  - Gaps in in_valid do not reset the phase.
- FIFO write: on the edge after stage 1 holds a kept sample, that sample is pushed.
  - Latency: sample accepted on edge E is visible at out_data, with out_valid=1 if the FIFO was empty, after edge E+1.
- FIFO read: a pop occurs on an edge where out_valid && out_ready. out_data always shows the head entry; it is held while out_valid && !out_ready.
- Full FIFO with push pending:
  - If a pop occurs in the same cycle, the push is accepted and level is unchanged.
  - Otherwise the sample is dropped, overflow is set, and FIFO contents are untouched.
- Empty FIFO with push and out_ready=1: no same-cycle bypass; out_valid rises next cycle.
- Pointers wrap modulo DEPTH. level = number of stored entries, 0..DEPTH.
- Sticky flags clear only on reset.

Decomposition:
- Shared package fir_pkg:
  - SAMPLE_W=16, ACC_W=32
  - SAT_MAX=32767, SAT_MIN=-32768
  - a sat_round function (round, shift, saturate) reused by future stages
- One sub-module: sync_fifo (parameters WIDTH, DEPTH; ports push, pop, din, dout, full, empty, level).
- The top level contains stage 1, the decimation counter and the flags.

Test Plan:
1. Rounding (SHIFT=4, DECIM=1): y_in=24, 23, -24, -25 -> out_data=2, 1, -1, -2. sat_seen=0.
2. Saturation: y_in=32'h7FFFFFFF then 32'h80000000 -> out_data=32767 then -32768. sat_seen=1 and stays 1 afterwards.
3. Decimation (DECIM=2, out_ready=1):
   - y_in=16, 32, 48, 64, 80, 96 on consecutive cycles -> outputs 1, 3, 5.
   - First out_valid appears after the edge following the acceptance of 16.
   - Repeat with in_valid low on alternate cycles -> same output values.
4. Backpressure/overflow (DEPTH=4, DECIM=1, out_ready=0):
   - Feed 16, 32, 48, 64, 80 -> level=4, overflow=1.
   - Then out_ready=1 -> drains 1, 2, 3, 4 in order; 5 never appears.
5. Full with simultaneous pop: with level=4 and out_ready=1, push 80 -> level stays 4, overflow stays 0, and 5 is eventually output.
6. Reset mid-stream: with level=3, pulse reset for one cycle -> out_valid=0, level=0, flags=0. The next accepted sample (DECIM=2) is kept.
